// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution unit: condition-code
// encodings (instruction bits 31:28) and bit positions in the {N,Z,C,V} flag word.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage : cond_pkg

// File: rtl/cond_check.sv
// Condition evaluator: maps the 4-bit condition field and the stored
// {N,Z,C,V} flags to a single execute/suppress decision. Purely combinational.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  // Decode the condition; the reserved NV encoding never executes.
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      EQ: cond_ex_o = z;
      NE: cond_ex_o = ~z;
      CS: cond_ex_o = c;
      CC: cond_ex_o = ~c;
      MI: cond_ex_o = n;
      PL: cond_ex_o = ~n;
      VS: cond_ex_o = v;
      VC: cond_ex_o = ~v;
      HI: cond_ex_o = c & ~z;
      LS: cond_ex_o = ~c | z;
      GE: cond_ex_o = ~(n ^ v);
      LT: cond_ex_o = n ^ v;
      GT: cond_ex_o = ~z & ~(n ^ v);
      LE: cond_ex_o = z | (n ^ v);
      AL: cond_ex_o = 1'b1;
      NV: cond_ex_o = 1'b0;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule : cond_check

// File: rtl/conditional_logic.sv
// Conditional-execution unit: holds the NZCV flag register, evaluates the
// instruction condition against the stored (pre-update) flags and gates the
// decoder's PC-source, register-write, memory-write and flag-write requests.
// Optional debug visibility of the flags and CondEx via CONDLOGIC_DEBUG_EN.
module conditional_logic
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PCs,
  input  logic       RegW,
  input  logic       MemW,
  input  logic [1:0] FlagW,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
`ifdef CONDLOGIC_DEBUG_EN
  ,
  output logic [3:0] Flags_q,
  output logic [0:0] CondEx_o
`endif
);

  // NZ and CV are written independently, so they are kept as separate fields.
  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       cond_ex;

  cond_check u_cond_check (
    .cond_i    (Cond),
    .flags_i   ({nz_q, cv_q}),
    .cond_ex_o (cond_ex)
  );

  // Write enables follow the decoder only when the condition passes.
  assign PCSrc    = PCs  & cond_ex;
  assign RegWrite = RegW & cond_ex;
  assign MemWrite = MemW & cond_ex;

  // Next-state flags: a failed condition also suppresses the flag update.
  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (FlagW[1] & cond_ex) nz_d = ALUFlags[FLAG_N:FLAG_Z];
    if (FlagW[0] & cond_ex) cv_d = ALUFlags[FLAG_C:FLAG_V];
  end

  // Flag register; reset clears it immediately so CondEx sees zero flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

`ifdef CONDLOGIC_DEBUG_EN
  assign Flags_q  = {nz_q, cv_q};
  assign CondEx_o = cond_ex;
`endif

endmodule : conditional_logic

// File: tb/tb_conditional_logic.sv
// Self-checking bench for conditional_logic: directed scenarios plus random
// traffic against a behavioural model of the flags and condition rules.
// Stored flags are observed through the outputs by sweeping all conditions.
module tb_conditional_logic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       PCs, RegW, MemW;
  logic [1:0] FlagW;
  logic [3:0] Cond, ALUFlags;
  logic       PCSrc, RegWrite, MemWrite;
`ifdef CONDLOGIC_DEBUG_EN
  logic [3:0] Flags_q;
  logic [0:0] CondEx_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] mflags;   // model of the architectural flags {N,Z,C,V}

  always #50 clk = ~clk;

  conditional_logic dut (
    .clk(clk), .rst_n(rst_n), .PCs(PCs), .RegW(RegW), .MemW(MemW),
    .FlagW(FlagW), .Cond(Cond), .ALUFlags(ALUFlags),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite)
`ifdef CONDLOGIC_DEBUG_EN
    , .Flags_q(Flags_q), .CondEx_o(CondEx_o)
`endif
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Condition rules: even codes test a base predicate, odd codes its inverse.
  function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !b : b;
  endfunction

  task automatic drive(input logic pcs, input logic rw, input logic mw,
                       input logic [1:0] fw, input logic [3:0] c, input logic [3:0] a);
    PCs = pcs; RegW = rw; MemW = mw; FlagW = fw; Cond = c; ALUFlags = a;
  endtask

  // Check the gated outputs against the model for the current inputs.
  task automatic chk_outs(input string tag);
    logic e;
    e = passes(Cond, mflags);
    chk({tag, ".pcsrc"}, {3'b0, PCSrc},    {3'b0, PCs  & e});
    chk({tag, ".regw"},  {3'b0, RegWrite}, {3'b0, RegW & e});
    chk({tag, ".memw"},  {3'b0, MemWrite}, {3'b0, MemW & e});
`ifdef CONDLOGIC_DEBUG_EN
    chk({tag, ".flags"}, Flags_q, mflags);
    chk({tag, ".condex"}, {3'b0, CondEx_o}, {3'b0, e});
`endif
  endtask

  // Called in the clock-low phase: check outputs, then take one rising edge
  // and advance the model, returning in the next low phase.
  task automatic cycle(input string tag);
    logic e;
    #1;
    chk_outs(tag);
    e = passes(Cond, mflags);
    @(posedge clk);
    if (e && FlagW[1]) mflags[3:2] = ALUFlags[3:2];
    if (e && FlagW[0]) mflags[1:0] = ALUFlags[1:0];
    @(negedge clk);
  endtask

  // Observe stored flags: every condition with all requests set, FlagW=0.
  task automatic sweep(input string tag);
    logic e;
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 1'b1, 1'b1, 2'b00, c[3:0], 4'h0);
      #2;
      e = passes(c[3:0], mflags);
      chk($sformatf("%s.c%0d", tag, c), {1'b0, PCSrc, RegWrite, MemWrite}, {1'b0, e, e, e});
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive(1'b0, 1'b0, 1'b0, 2'b11, 4'hE, f);
    cycle("setf");
  endtask

  logic [3:0] fv [5];

  initial begin
    fv[0] = 4'b0000; fv[1] = 4'b0100; fv[2] = 4'b1001; fv[3] = 4'b0010; fv[4] = 4'b1000;
    mflags = 4'b0000;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'hE, 4'h0);
    #20;
    chk("rst.regw", {3'b0, RegWrite}, 4'b0001);
    chk("rst.pcsrc", {3'b0, PCSrc}, 4'b0000);
    chk("rst.memw", {3'b0, MemWrite}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("al");
    sweep("post_al");

    // NE with flag write: passes against old flags, then N becomes set.
    drive(1'b0, 1'b1, 1'b0, 2'b11, 4'h1, 4'h8);
    cycle("ne1");
    chk("ne1.model", mflags, 4'b1000);
    cycle("ne2");
    drive(1'b0, 1'b1, 1'b0, 2'b11, 4'h1, 4'h7);
    cycle("ne3");
    chk("ne3.model", mflags, 4'b0111);
    for (int i = 0; i < 3; i++) cycle("ne_fail");
    chk("ne_hold.regw", {3'b0, RegWrite}, 4'b0000);
    sweep("ne_hold");

    // Full condition table over selected flag values.
    foreach (fv[k]) begin
      set_flags(fv[k]);
      sweep($sformatf("tbl%0d", k));
    end

    // Partial flag writes.
    set_flags(4'b0000);
    drive(1'b0, 1'b0, 1'b0, 2'b10, 4'hE, 4'b1111);
    cycle("fw10");
    sweep("fw10");
    drive(1'b0, 1'b0, 1'b0, 2'b01, 4'hE, 4'b0000);
    cycle("fw01");
    sweep("fw01");

    // Mid-cycle asynchronous reset.
    set_flags(4'b1111);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    #5;
    chk("prerst.regw", {3'b0, RegWrite}, 4'b0001);
    #10;
    rst_n = 1'b0;
    mflags = 4'b0000;
    #1;
    chk("midrst.regw", {3'b0, RegWrite}, 4'b0000);
    sweep("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with periodic flag observation.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(1), $urandom_range(1), $urandom_range(1),
            $urandom_range(3), $urandom_range(15), $urandom_range(15));
      cycle("rnd");
      if (i % 25 == 24) sweep("rnd_sw");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_conditional_logic
